// File: rtl/conv_sequencer.sv
// conv_sequencer: frame sequencer that loads a 3x3 kernel, streams pixels into a
// 3-row circular line buffer and paces one convolution engine run per output row.
module conv_sequencer #(
    parameter int BIT_DEPTH = 8,
    parameter int COLS      = 28,
    parameter int IMG_ROWS  = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic [1:0]           stride,
    input  logic                 kin_valid,
    input  logic [BIT_DEPTH-1:0] kin_data,
    output logic                 kin_ready,
    input  logic                 pix_valid,
    input  logic [BIT_DEPTH-1:0] pix_data,
    output logic                 pix_ready,
    output logic                 kernel_wr_en,
    output logic [3:0]           kernel_addr,
    output logic [BIT_DEPTH-1:0] kernel_wdata,
    output logic                 lb_wr_en,
    output logic [1:0]           lb_wr_row,
    output logic [4:0]           lb_wr_col,
    output logic [BIT_DEPTH-1:0] lb_wdata,
    output logic                 conv_start,
    input  logic                 conv_done,
    output logic                 busy,
    output logic                 frame_done,
    output logic [4:0]           out_row
);
    typedef enum logic [2:0] {IDLE, LOAD_K, FILL, CONV_GO, CONV_WAIT, REFILL, FINISH} state_t;
    localparam logic [4:0] LAST_COL  = 5'(COLS - 1);
    localparam logic [4:0] LAST_ROW1 = 5'(IMG_ROWS - 3);
    localparam logic [4:0] LAST_ROW2 = 5'((IMG_ROWS - 3) / 2);
    state_t      state_q, state_d;
    logic [1:0]  stride_q, stride_d, row_q, row_d, rows_left_q, rows_left_d;
    logic [3:0]  k_cnt_q, k_cnt_d;
    logic [4:0]  col_q, col_d, out_row_q, out_row_d, last_row;
    logic        kin_hs, pix_hs;
    assign kin_ready    = state_q == LOAD_K;
    assign pix_ready    = state_q == FILL || state_q == REFILL;
    assign kin_hs       = kin_valid && kin_ready;
    assign pix_hs       = pix_valid && pix_ready;
    assign kernel_wr_en = kin_hs;
    assign kernel_addr  = k_cnt_q;
    assign kernel_wdata = kin_hs ? kin_data : '0;
    assign lb_wr_en     = pix_hs;
    assign lb_wr_row    = row_q;
    assign lb_wr_col    = col_q;
    assign lb_wdata     = pix_hs ? pix_data : '0;
    assign conv_start   = state_q == CONV_GO;
    assign frame_done   = state_q == FINISH;
    assign busy         = state_q != IDLE && state_q != FINISH;
    assign out_row      = out_row_q;
    assign last_row     = stride_q == 2'd2 ? LAST_ROW2 : LAST_ROW1;
    // row_q is both the write row and the oldest-row pointer: refills always overwrite oldest first
    always_comb begin
        state_d     = state_q;
        stride_d    = stride_q;
        row_d       = row_q;
        rows_left_d = rows_left_q;
        k_cnt_d     = k_cnt_q;
        col_d       = col_q;
        out_row_d   = out_row_q;
        case (state_q)
            IDLE: if (frame_start) begin
                stride_d = stride == 2'd2 ? 2'd2 : 2'd1;
                k_cnt_d  = '0;
                state_d  = LOAD_K;
            end
            LOAD_K: if (kin_hs) begin
                k_cnt_d = k_cnt_q == 4'd8 ? 4'd0 : k_cnt_q + 4'd1;
                if (k_cnt_q == 4'd8) begin
                    state_d     = FILL;
                    rows_left_d = 2'd3;
                    row_d       = '0;
                    col_d       = '0;
                end
            end
            FILL, REFILL: if (pix_hs) begin
                col_d = col_q == LAST_COL ? 5'd0 : col_q + 5'd1;
                if (col_q == LAST_COL) begin
                    row_d       = row_q == 2'd2 ? 2'd0 : row_q + 2'd1;
                    rows_left_d = rows_left_q - 2'd1;
                    if (rows_left_q == 2'd1) state_d = CONV_GO;
                end
            end
            CONV_GO: state_d = CONV_WAIT;
            CONV_WAIT: if (conv_done) begin
                state_d     = out_row_q == last_row ? FINISH : REFILL;
                out_row_d   = out_row_q == last_row ? 5'd0 : out_row_q + 5'd1;
                rows_left_d = stride_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            stride_q    <= '0;
            row_q       <= '0;
            rows_left_q <= '0;
            k_cnt_q     <= '0;
            col_q       <= '0;
            out_row_q   <= '0;
        end else begin
            state_q     <= state_d;
            stride_q    <= stride_d;
            row_q       <= row_d;
            rows_left_q <= rows_left_d;
            k_cnt_q     <= k_cnt_d;
            col_q       <= col_d;
            out_row_q   <= out_row_d;
        end
    end
endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: directed frames with a queue scoreboard for kernel and line-buffer writes.
module tb_conv_sequencer;
    localparam int COLS = 28, IMG_ROWS = 28;
    logic       clk = 0, rst = 1, fs_drv = 0, fs_spur = 0, frame_start;
    logic [1:0] stride = 0;
    logic       kin_valid = 0, kin_ready, pix_valid = 0, pix_ready;
    logic [7:0] kin_data = 0, pix_data = 0, kernel_wdata, lb_wdata;
    logic       kernel_wr_en, lb_wr_en, conv_start, busy, frame_done;
    logic       cd_eng = 0, cd_spur = 0, conv_done;
    logic [3:0] kernel_addr;
    logic [1:0] lb_wr_row;
    logic [4:0] lb_wr_col, out_row;
    assign frame_start = fs_drv | fs_spur;
    assign conv_done   = cd_eng | cd_spur;
    conv_sequencer #(.BIT_DEPTH(8), .COLS(COLS), .IMG_ROWS(IMG_ROWS)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .stride(stride),
        .kin_valid(kin_valid), .kin_data(kin_data), .kin_ready(kin_ready),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .kernel_wr_en(kernel_wr_en), .kernel_addr(kernel_addr), .kernel_wdata(kernel_wdata),
        .lb_wr_en(lb_wr_en), .lb_wr_row(lb_wr_row), .lb_wr_col(lb_wr_col), .lb_wdata(lb_wdata),
        .conv_start(conv_start), .conv_done(conv_done), .busy(busy),
        .frame_done(frame_done), .out_row(out_row));
    always #5 clk = ~clk;
    typedef struct {logic [1:0] row; logic [4:0] col; logic [7:0] d;} pix_t;
    pix_t        pq[$];
    pix_t        pe;
    logic [11:0] kq[$];
    logic [11:0] ke;
    int n_checks = 0, n_fail = 0, cs_cnt = 0, fd_cnt = 0;
    bit spur_fs_en = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [63:0] all_outs();
        return {kin_ready, pix_ready, busy, conv_start, frame_done, lb_wr_en, kernel_wr_en,
                out_row, lb_wr_row, lb_wr_col, kernel_addr, lb_wdata, kernel_wdata};
    endfunction
    always @(negedge clk) begin
        if (conv_start) cs_cnt++;
        if (frame_done) fd_cnt++;
        if (kernel_wr_en) begin
            if (kq.size() == 0) chk("kernel_unexpected_write", 1, 0);
            else begin
                ke = kq.pop_front();
                chk("kernel_addr", kernel_addr, ke[11:8]);
                chk("kernel_wdata", kernel_wdata, ke[7:0]);
            end
        end
        if (lb_wr_en) begin
            if (pq.size() == 0) chk("lb_unexpected_write", 1, 0);
            else begin
                pe = pq.pop_front();
                chk("lb_wr_row", lb_wr_row, pe.row);
                chk("lb_wr_col", lb_wr_col, pe.col);
                chk("lb_wdata", lb_wdata, pe.d);
            end
        end
    end
    // behavioural convolution engine: done 5 cycles after start, optionally poking frame_start mid-wait
    initial forever begin
        @(negedge clk);
        if (conv_start) begin
            if (spur_fs_en) begin
                @(posedge clk); #1 fs_spur = 1;
                @(posedge clk); #1 fs_spur = 0;
                repeat (3) @(posedge clk);
            end else repeat (5) @(posedge clk);
            #1 cd_eng = 1;
            @(posedge clk); #1 cd_eng = 0;
        end
    end
    task automatic wait_ready(input bit is_pix, output bit ok);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (is_pix ? pix_ready : kin_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk(is_pix ? "pix_ready_timeout" : "kin_ready_timeout", 0, 1);
        @(posedge clk); #1;
    endtask
    task automatic run_frame(input int s, input bit bp, input bit spur, input int rst_row);
        int  n, rows, cs0, fd0, eff;
        bit  ok, got;
        logic [7:0] d;
        eff  = (s == 2) ? 2 : 1;
        n    = (IMG_ROWS - 3) / eff + 1;
        rows = 3 + (n - 1) * eff;
        cs0  = cs_cnt;
        fd0  = fd_cnt;
        spur_fs_en = spur;
        @(posedge clk); #1 fs_drv = 1; stride = 2'(s);
        @(posedge clk); #1 fs_drv = 0; stride = 2'd3;
        chk("busy_after_start", busy, 1);
        for (int k = 0; k < 9; k++) begin
            kq.push_back({4'(k), 8'(k + 1)});
            kin_valid = 1;
            kin_data  = 8'(k + 1);
            wait_ready(0, ok);
            if (!ok) return;
        end
        kin_valid = 0;
        chk("kin_ready_after_9th", kin_ready, 0);
        chk("pix_ready_in_fill", pix_ready, 1);
        if (spur) begin
            cd_spur = 1;
            @(posedge clk); #1 cd_spur = 0;
            chk("spurious_done_fill_ready", pix_ready, 1);
            chk("spurious_done_no_start", cs_cnt - cs0, 0);
        end
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < COLS; c++) begin
                if (r == rst_row && c == 5) begin
                    chk("out_row_before_reset", out_row, 7);
                    #2 rst = 1;
                    #1 chk("outputs_in_midframe_reset", all_outs(), 0);
                    pix_valid = 0;
                    repeat (3) @(posedge clk);
                    #1 rst = 0;
                    pq.delete();
                    repeat (10) @(posedge clk);
                    #1 chk("no_frame_done_after_abort", fd_cnt - fd0, 0);
                    chk("idle_after_abort", busy, 0);
                    return;
                end
                d = 8'(r * 7 + c * 3 + 1);
                pq.push_back('{row: 2'(r % 3), col: 5'(c), d: d});
                pix_valid = 1;
                pix_data  = d;
                wait_ready(1, ok);
                if (!ok) return;
                if (bp) begin
                    pix_valid = 0;
                    @(posedge clk); #1;
                end
            end
        pix_valid = 0;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_done) begin
                got = 1;
                chk("busy_at_frame_done", busy, 0);
                chk("out_row_at_frame_done", out_row, 0);
                break;
            end
        end
        chk("frame_done_seen", got, 1);
        repeat (3) @(posedge clk);
        #1 chk("conv_start_count", cs_cnt - cs0, n);
        chk("frame_done_count", fd_cnt - fd0, 1);
        chk("pixel_queue_drained", pq.size(), 0);
        chk("kernel_queue_drained", kq.size(), 0);
        spur_fs_en = 0;
    endtask
    initial begin
        kin_valid = 1; pix_valid = 1; kin_data = 8'hA5; pix_data = 8'h5A; fs_drv = 1;
        repeat (2) @(posedge clk);
        #1 chk("outputs_in_reset", all_outs(), 0);
        kin_valid = 0; pix_valid = 0; fs_drv = 0;
        rst = 0;
        @(posedge clk); #1 chk("idle_not_busy", busy, 0);
        run_frame(1, 0, 0, -1);
        run_frame(2, 0, 0, -1);
        run_frame(1, 1, 1, -1);
        run_frame(1, 0, 0, 9);
        run_frame(1, 0, 0, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
